// File: rtl/column_window_feeder.sv
// column_window_feeder: turns a raster pixel stream into vertical 3-tap columns
// (a = row above, b = centre row, c = row below) for the a + 2b + c edge ALU.
// Two line buffers hold the previous rows; the output register drives the ALU.
// Build option: define EDGE_REPLICATE_EN to replicate the centre pixel into the
// missing top/bottom tap instead of zero padding.
module column_window_feeder #(
  parameter int unsigned IMG_W = 352,
  parameter int unsigned IMG_H = 288,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_a,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_c,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StFill, StStream, StFlush} state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] lb_prev_q [IMG_W];
  logic [PIX_W-1:0] lb_prev_d [IMG_W];
  logic [PIX_W-1:0] lb_cur_q  [IMG_W];
  logic [PIX_W-1:0] lb_cur_d  [IMG_W];
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
  logic             out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_eof_q, out_eof_d;

  logic             in_ready_c;
  logic             out_free;
  logic             start;
  logic [PIX_W-1:0] b_v, top_pad, bot_pad;

  // Next-state, line buffer update and output register load.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    row_d       = row_q;
    lb_prev_d   = lb_prev_q;
    lb_cur_d    = lb_cur_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    in_ready_c  = 1'b0;
    start       = 1'b0;
    out_free    = !out_valid_q || out_ready;
    b_v         = lb_cur_q[x_q];
`ifdef EDGE_REPLICATE_EN
    top_pad     = b_v;
    bot_pad     = b_v;
`else
    top_pad     = '0;
    bot_pad     = '0;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready_c = 1'b1;
        if (in_valid && in_sof) start = 1'b1;
      end
      StFill: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          if (in_sof) begin
            start = 1'b1;
          end else begin
            lb_cur_d[x_q] = in_pixel;
            if (x_q == XLast) begin
              x_d     = '0;
              row_d   = YW'(1);
              state_d = StStream;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      StStream: begin
        in_ready_c = out_free;
        if (in_valid && out_free) begin
          if (in_sof) begin
            start = 1'b1;
          end else begin
            out_valid_d     = 1'b1;
            out_a_d         = (row_q == YW'(1)) ? top_pad : lb_prev_q[x_q];
            out_b_d         = b_v;
            out_c_d         = in_pixel;
            out_sof_d       = (row_q == YW'(1)) && (x_q == '0);
            out_eol_d       = (x_q == XLast);
            out_eof_d       = 1'b0;
            // Read-before-write: both buffers shift down one row at column x.
            lb_prev_d[x_q]  = b_v;
            lb_cur_d[x_q]   = in_pixel;
            if (x_q == XLast) begin
              x_d = '0;
              if (row_q == YLast) state_d = StFlush;
              else                row_d   = row_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      StFlush: begin
        if (out_valid_q && out_eof_q) begin
          // Last column loaded; leave once it has been taken.
          if (out_ready) state_d = StIdle;
        end else if (out_free) begin
          out_valid_d = 1'b1;
          out_a_d     = lb_prev_q[x_q];
          out_b_d     = b_v;
          out_c_d     = bot_pad;
          out_sof_d   = 1'b0;
          out_eol_d   = (x_q == XLast);
          out_eof_d   = (x_q == XLast);
          x_d         = (x_q == XLast) ? '0 : x_q + XW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A start-of-frame beat aborts whatever was in progress.
    if (start) begin
      lb_cur_d[0] = in_pixel;
      x_d         = XW'(1);
      row_d       = '0;
      out_valid_d = 1'b0;
      state_d     = StFill;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

  // Line buffers carry no reset; their contents are rewritten every frame.
  always_ff @(posedge clk) begin
    lb_prev_q <= lb_prev_d;
    lb_cur_q  <= lb_cur_d;
  end

  assign in_ready  = in_ready_c & ~rst;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_column_window_feeder.sv
// Bench for column_window_feeder (4x3 frames): random pixels and back-pressure
// checked against a column model computed directly from the frame contents.
module tb_column_window_feeder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       sof;
    logic       eol;
    logic       eof;
  } col_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sof;
  logic [7:0] in_pixel;
  logic       out_valid, out_ready;
  logic [7:0] out_a, out_b, out_c;
  logic       out_sof, out_eol, out_eof;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] fr [N];
  col_t       got_q[$];
  col_t       exp_q[$];
  int         ready_mode = 0;  // 0: always ready, 1: toggle, 2: random
  bit         phase_stream = 0;
  bit         prev_stall = 0;
  col_t       prev_col, cur_col;
  int         stall_viol = 0;
  int         ready_viol = 0;

  column_window_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Output monitor: records accepted columns, stall stability and in_ready rule.
  always @(negedge clk) begin
    cur_col = '{a: out_a, b: out_b, c: out_c, sof: out_sof, eol: out_eol, eof: out_eof};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (out_valid !== 1'b1 || cur_col !== prev_col)) stall_viol++;
      if (phase_stream && in_ready !== (!out_valid || out_ready)) ready_viol++;
      if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(cur_col);
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_col   = cur_col;
    end
  end

  // Reference column for centre row r, column x, from the frame rules.
  function automatic col_t model_col(int r, int x);
    col_t c;
    c.b = fr[r*W + x];
`ifdef EDGE_REPLICATE_EN
    c.a = (r == 0)     ? c.b : fr[(r-1)*W + x];
    c.c = (r == H - 1) ? c.b : fr[(r+1)*W + x];
`else
    c.a = (r == 0)     ? 8'd0 : fr[(r-1)*W + x];
    c.c = (r == H - 1) ? 8'd0 : fr[(r+1)*W + x];
`endif
    c.sof = (r == 0) && (x == 0);
    c.eol = (x == W - 1);
    c.eof = (r == H - 1) && (x == W - 1);
    return c;
  endfunction

  task automatic build_expected();
    exp_q = {};
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) exp_q.push_back(model_col(r, x));
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) fr[r*W + x] = 8'(16*r + x + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_pixels(input int first, input int count, input bit sof_first);
    for (int i = first; i < first + count; i++) begin
      int t;
      in_valid     = 1'b1;
      in_pixel     = fr[i];
      in_sof       = sof_first && (i == first);
      phase_stream = (i >= W);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready === 1'b1) break;
        t++;
        if (t > 200) begin
          tests_run++;
          tests_failed++;
          $display("FAIL send_timeout: pixel %0d not accepted, in_ready=%b required 1", i,
                   in_ready);
          in_valid = 1'b0; in_sof = 1'b0; phase_stream = 0;
          return;
        end
        tick();
      end
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0; phase_stream = 0;
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (got_q.size() < n && t < 500) begin
      tick();
      t++;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready,
               out_valid);
    end
    tests_run++;
    if ({out_a, out_b, out_c, out_sof, out_eol, out_eof} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: a=%0d b=%0d c=%0d flags=%b%b%b, required all 0", out_a,
               out_b, out_c, out_sof, out_eol, out_eof);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, required 1 0", in_ready,
               out_valid);
    end
    tick();
  endtask

  task automatic test_full_frame();
    ready_mode = 0; fill_pattern(); build_expected(); got_q = {};
    send_pixels(0, W, 1);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_no_output: out_valid=%b, required 0", out_valid);
    end
    tick();
    send_pixels(W, 1, 0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_b !== 8'd1 || out_c !== 8'd17) begin
      tests_failed++;
      $display("FAIL first_latency: valid=%b b=%0d c=%0d, required 1 1 17", out_valid, out_b,
               out_c);
    end
    tick();
    send_pixels(W + 1, N - W - 1, 0);
    wait_outputs(N);
    tests_run++;
    if (got_q.size() != N) begin
      tests_failed++;
      $display("FAIL full_count: got %0d columns, required %0d", got_q.size(), N);
    end
    for (int k = 0; k < N && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL full_col%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
    if (got_q.size() == N) begin
      col_t c0, c6, c11;
`ifdef EDGE_REPLICATE_EN
      c0 = '{a: 8'd1, b: 8'd1, c: 8'd17, sof: 1'b1, eol: 1'b0, eof: 1'b0};
      c11 = '{a: 8'd20, b: 8'd36, c: 8'd36, sof: 1'b0, eol: 1'b1, eof: 1'b1};
`else
      c0 = '{a: 8'd0, b: 8'd1, c: 8'd17, sof: 1'b1, eol: 1'b0, eof: 1'b0};
      c11 = '{a: 8'd20, b: 8'd36, c: 8'd0, sof: 1'b0, eol: 1'b1, eof: 1'b1};
`endif
      c6 = '{a: 8'd3, b: 8'd19, c: 8'd35, sof: 1'b0, eol: 1'b0, eof: 1'b0};
      tests_run++;
      if (got_q[0] !== c0 || got_q[6] !== c6 || got_q[11] !== c11) begin
        tests_failed++;
        $display("FAIL full_known: got %h %h %h, required %h %h %h", got_q[0], got_q[6],
                 got_q[11], c0, c6, c11);
      end
    end
  endtask

  task automatic test_back_pressure(input int mode, input bit rand_pix, input string name);
    ready_mode = mode;
    if (rand_pix) fill_random(); else fill_pattern();
    build_expected(); got_q = {}; stall_viol = 0; ready_viol = 0;
    send_pixels(0, N, 1);
    wait_outputs(N);
    tests_run++;
    if (got_q.size() != N) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d columns, required %0d", name, got_q.size(), N);
    end
    for (int k = 0; k < N && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL %s_col%0d: got %h, required %h", name, k, got_q[k], exp_q[k]);
      end
    end
    tests_run++;
    if (stall_viol != 0 || ready_viol != 0) begin
      tests_failed++;
      $display("FAIL %s_stall: stall_viol=%0d ready_viol=%0d, required 0 0", name,
               stall_viol, ready_viol);
    end
    ready_mode = 0;
  endtask

  task automatic test_abort();
    col_t first_a;
    ready_mode = 0; fill_random(); got_q = {};
    first_a = model_col(0, 0);
    send_pixels(0, W + 1, 1);
    fill_random(); build_expected();
    exp_q.push_front(first_a);
    send_pixels(0, 1, 1);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_drop: out_valid=%b, required 0", out_valid);
    end
    tick();
    send_pixels(1, N - 1, 0);
    wait_outputs(N + 1);
    tests_run++;
    if (got_q.size() != N + 1) begin
      tests_failed++;
      $display("FAIL abort_count: got %0d columns, required %0d", got_q.size(), N + 1);
    end
    for (int k = 0; k < N + 1 && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL abort_col%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_no_sof();
    int not_ready = 0;
    ready_mode = 0; got_q = {};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (in_ready !== 1'b1) not_ready++;
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    tests_run++;
    if (not_ready != 0) begin
      tests_failed++;
      $display("FAIL nosof_ready: %0d cycles with in_ready low, required 0", not_ready);
    end
    tests_run++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nosof_output: got %0d columns out_valid=%b, required 0 0", got_q.size(),
               out_valid);
    end
  endtask

  task automatic test_reset_in_flush();
    ready_mode = 0; fill_random();
    send_pixels(0, N, 1);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_reset: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    got_q = {};
    fill_random(); build_expected();
    send_pixels(0, N, 1);
    wait_outputs(N);
    tests_run++;
    if (got_q.size() != N) begin
      tests_failed++;
      $display("FAIL post_reset_count: got %0d columns, required %0d", got_q.size(), N);
    end
    for (int k = 0; k < N && k < got_q.size(); k++) begin
      tests_run++;
      if (got_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL post_reset_col%0d: got %h, required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_pressure(1, 0, "toggle");
    test_back_pressure(2, 1, "random_a");
    test_back_pressure(2, 1, "random_b");
    test_abort();
    test_no_sof();
    test_back_pressure(0, 1, "after_nosof");
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
